// File: rtl/kmem_rr_arbiter.sv
// rtl/kmem_rr_arbiter.sv - round-robin Avalon-MM arbiter for kernel memory ports
// Write bursts lock the grant; read responses are routed back in command order.
module kmem_rr_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int ADDR_WIDTH     = 31,
  parameter int DATA_WIDTH     = 512,
  parameter int BURSTCNT_WIDTH = 5,
  parameter int RD_FIFO_DEPTH  = 64
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]       p_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]       p_writedata,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]   p_byteenable,
  input  logic [NUM_PORTS*BURSTCNT_WIDTH-1:0]   p_burstcount,
  input  logic [NUM_PORTS-1:0]                  p_read,
  input  logic [NUM_PORTS-1:0]                  p_write,
  output logic [NUM_PORTS-1:0]                  p_waitrequest,
  output logic [DATA_WIDTH-1:0]                 p_readdata,
  output logic [NUM_PORTS-1:0]                  p_readdatavalid,
  output logic [ADDR_WIDTH-1:0]                 m_address,
  output logic [DATA_WIDTH-1:0]                 m_writedata,
  output logic [(DATA_WIDTH/8)-1:0]             m_byteenable,
  output logic [BURSTCNT_WIDTH-1:0]             m_burstcount,
  output logic                                  m_read,
  output logic                                  m_write,
  input  logic                                  m_waitrequest,
  input  logic [DATA_WIDTH-1:0]                 m_readdata,
  input  logic                                  m_readdatavalid,
  output logic [$clog2(RD_FIFO_DEPTH):0]        rd_pending,
  output logic                                  rsp_orphan
);
  localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int BEW = DATA_WIDTH / 8;
  localparam int BW  = BURSTCNT_WIDTH;
  localparam int FAW = $clog2(RD_FIFO_DEPTH);
  localparam int CW  = FAW + 1;

  typedef enum logic {ST_ARB = 1'b0, ST_WR_LOCK = 1'b1} state_t;

  state_t            r_state;
  logic [PW-1:0]     r_last_grant;
  logic [BW-1:0]     r_wr_cnt;

  logic [PW-1:0]     r_fifo_port [RD_FIFO_DEPTH];
  logic [BW-1:0]     r_fifo_len  [RD_FIFO_DEPTH];
  logic [FAW-1:0]    r_wr_ptr;
  logic [FAW-1:0]    r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [BW-1:0]     r_beat_cnt;
  logic [NUM_PORTS-1:0]  r_rdv;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic              r_orphan;

  state_t            w_state_nxt;
  logic [PW-1:0]     w_last_grant_nxt;
  logic [BW-1:0]     w_wr_cnt_nxt;
  logic [NUM_PORTS-1:0] w_req;
  logic [PW-1:0]     w_cand [NUM_PORTS];
  logic              w_gnt_valid;
  logic [PW-1:0]     w_gnt_idx;
  logic              w_gnt_wr;
  logic [BW-1:0]     w_eff_bc;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_accept;
  logic              w_push;
  logic              w_beat;
  logic              w_pop;
  logic [PW-1:0]     w_head_port;
  logic [BW-1:0]     w_head_len;

  assign w_req = p_read | p_write;

  // Search order for the rotating priority: the port right after last_grant first.
  always_comb begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_cand[k] = PW'((int'(r_last_grant) + k + 1) % NUM_PORTS);
    end
  end

  assign m_address    = p_address[int'(w_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_writedata  = p_writedata[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign m_byteenable = p_byteenable[int'(w_gnt_idx)*BEW +: BEW];
  assign m_burstcount = p_burstcount[int'(w_gnt_idx)*BW +: BW];
  assign w_eff_bc     = (m_burstcount == '0) ? BW'(1) : m_burstcount;

  assign w_fifo_full  = (r_count == CW'(RD_FIFO_DEPTH));
  assign w_fifo_empty = (r_count == '0);

  always_comb begin
    w_gnt_valid      = 1'b0;
    w_gnt_idx        = r_last_grant;
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_wr_cnt_nxt     = r_wr_cnt;

    if (r_state == ST_WR_LOCK) begin
      w_gnt_valid = p_write[r_last_grant];
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (!w_gnt_valid && w_req[w_cand[k]]) begin
          w_gnt_valid = 1'b1;
          w_gnt_idx   = w_cand[k];
        end
      end
    end

    // m_read is withheld while the route FIFO is full so the memory never
    // takes a read the port still sees as stalled.
    w_gnt_wr = p_write[w_gnt_idx];
    m_write  = reset_n & w_gnt_valid & w_gnt_wr;
    m_read   = reset_n & w_gnt_valid & ~w_gnt_wr & (r_state == ST_ARB) & ~w_fifo_full;
    w_accept = (m_read | m_write) & ~m_waitrequest;

    p_waitrequest = '1;
    if (w_accept) begin
      p_waitrequest[w_gnt_idx] = 1'b0;
      w_last_grant_nxt = w_gnt_idx;
      case (r_state)
        ST_ARB: begin
          if (w_gnt_wr && (w_eff_bc > BW'(1))) begin
            w_state_nxt  = ST_WR_LOCK;
            w_wr_cnt_nxt = w_eff_bc - BW'(1);
          end
        end
        ST_WR_LOCK: begin
          w_wr_cnt_nxt = r_wr_cnt - BW'(1);
          if (r_wr_cnt == BW'(1)) begin
            w_state_nxt = ST_ARB;
          end
        end
        default: w_state_nxt = ST_ARB;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= ST_ARB;
      r_last_grant <= PW'(NUM_PORTS - 1);
      r_wr_cnt     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_wr_cnt     <= w_wr_cnt_nxt;
    end
  end

  assign w_push      = m_read & ~m_waitrequest;
  assign w_head_port = r_fifo_port[r_rd_ptr];
  assign w_head_len  = r_fifo_len[r_rd_ptr];
  assign w_beat      = m_readdatavalid & ~w_fifo_empty;
  assign w_pop       = w_beat & (r_beat_cnt == (w_head_len - BW'(1)));

  // Route storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_port[r_wr_ptr] <= w_gnt_idx;
      r_fifo_len[r_wr_ptr]  <= w_eff_bc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_beat_cnt <= '0;
      r_rdv      <= '0;
      r_rdata    <= '0;
      r_orphan   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_beat) begin
        r_beat_cnt <= w_pop ? '0 : (r_beat_cnt + 1'b1);
        r_rdv      <= NUM_PORTS'(1) << w_head_port;
        r_rdata    <= m_readdata;
      end else begin
        r_rdv      <= '0;
      end
      if (m_readdatavalid && w_fifo_empty) begin
        r_orphan <= 1'b1;
      end
    end
  end

  assign p_readdatavalid = r_rdv;
  assign p_readdata      = r_rdata;
  assign rd_pending      = r_count;
  assign rsp_orphan      = r_orphan;

endmodule

// File: doc/kmem_rr_arbiter.md
KMEM_RR_ARBITER -- requirements
Module: kmem_rr_arbiter

Interface
REQ-001 SHALL expose parameter NUM_PORTS, default 4, number of kernel-side Avalon-MM ports (legal 2..8).
REQ-002 SHALL expose parameter ADDR_WIDTH, default 31, byte-address width.
REQ-003 SHALL expose parameter DATA_WIDTH, default 512, data width; byteenable width is DATA_WIDTH/8.
REQ-004 SHALL expose parameter BURSTCNT_WIDTH, default 5, burstcount width.
REQ-005 SHALL expose parameter RD_FIFO_DEPTH, default 64, read-route FIFO entries (power of 2, >=4).
REQ-006 SHALL provide clk  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL provide reset_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-008 SHALL provide p_address/p_writedata/p_byteenable/p_burstcount  input  NUM_PORTS x field width (port i in slice i)  per-port command fields.
REQ-009 SHALL provide p_read, p_write  input  NUM_PORTS  per-port command strobes.
REQ-010 SHALL provide p_waitrequest  output  NUM_PORTS  per-port stall.
REQ-011 SHALL provide p_readdata  output  DATA_WIDTH  read data, broadcast to all ports.
REQ-012 SHALL provide p_readdatavalid  output  NUM_PORTS  per-port read beat valid.
REQ-013 SHALL provide m_address, m_writedata, m_byteenable, m_burstcount, m_read, m_write  output  field widths  memory-side command.
REQ-014 SHALL provide m_waitrequest, m_readdata, m_readdatavalid  input  1/DATA_WIDTH/1  memory-side response.
REQ-015 SHALL provide rd_pending  output  clog2(RD_FIFO_DEPTH)+1  occupied route-FIFO entries.
REQ-016 SHALL provide rsp_orphan  output  1  sticky: beat received with route FIFO empty.

Function
REQ-017 A command SHALL be accepted when its read or write is high and its waitrequest is low in the same cycle.
REQ-018 Arbiter state SHALL be ARB (free grant) or WR_LOCK (write burst in progress).
REQ-019 In ARB, grant SHALL go to the first requesting port after last_grant in ascending index order, wrapping NUM_PORTS-1 to 0; last_grant resets to NUM_PORTS-1 so port 0 wins first.
REQ-020 Granted port's fields SHALL be muxed combinationally to m_*; zero added command latency.
REQ-021 p_waitrequest SHALL be low only for the granted port, and only when m_waitrequest is low and (for reads) the route FIFO is not full; all other ports high.
REQ-022 last_grant SHALL update only on an accepted command, never on a stalled grant.
REQ-023 Accepted write with burstcount N>1 SHALL enter WR_LOCK with beat counter N-1; grant held on that port until counter reaches 0 on an accepted beat, then return to ARB.
REQ-024 In WR_LOCK, requests from other ports SHALL be ignored; m_read SHALL be 0.
REQ-025 Burstcount 0 SHALL be treated as 1 for locking and read routing.
REQ-026 Accepted read SHALL push {port index, burstcount} into route FIFO in the accept cycle.
REQ-027 Route FIFO full SHALL block read acceptance even if a pop occurs the same cycle; writes are not blocked by FIFO full.
REQ-028 Each m_readdatavalid beat SHALL be registered: p_readdata and p_readdatavalid[head port] assert exactly 1 cycle later; others 0.
REQ-029 Beat counter SHALL pop the head entry on its last beat; next entry's beats route from the following beat, no gap required.
REQ-030 Beat with FIFO empty SHALL be dropped and set rsp_orphan until reset.
REQ-031 rd_pending SHALL be correct for simultaneous push and pop (unchanged).
REQ-032 Responses SHALL be returned in command order; no reordering.

Reset
REQ-033 On reset_n low at a clock edge: state ARB, last_grant NUM_PORTS-1, FIFO flushed, counters 0, rd_pending 0, rsp_orphan 0, p_readdatavalid 0, registered p_readdata 0.
REQ-034 Reset mid-burst SHALL abandon WR_LOCK and outstanding reads without further routing.
REQ-035 While reset_n is low, m_read, m_write SHALL be 0 and p_waitrequest all ones.

Verification
REQ-036 Ports 0-3 issue single-beat reads continuously, m_waitrequest 0 -> grants 0,1,2,3,0... one per cycle; each port's data returns to it only.
REQ-037 Port 1 write burstcount 4 while port 2 requests, m_waitrequest high on beat 2 -> port 1 receives all 4 beats before port 2 granted; port 2 waitrequest high throughout.
REQ-038 RD_FIFO_DEPTH=4, memory withholds responses, 5 reads -> 5th stalled, rd_pending 4; one head pop -> 5th accepted next cycle.
REQ-039 Reads port 3 burst 2 then port 0 burst 3, 5 back-to-back beats -> p_readdatavalid[3] 2 cycles then [0] 3 cycles, each 1 cycle after m_readdatavalid.
REQ-040 Beat with no outstanding read -> no p_readdatavalid, rsp_orphan 1 until reset.
REQ-041 reset_n low for 1 cycle during write burst beat 2 of 8 -> next cycle state ARB, port 0 wins if requesting, rd_pending 0.
